// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS Avalon-MM test memory.
// Holds the transfer FSM encoding, the default boot-region base and the byte-lane merge.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] INSTR_BASE_DEFAULT = 32'hBFC0_0000;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mips_bus_if.sv
// Avalon-MM bus between the CPU master port and the test memory slave.
interface mips_bus_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, bus_error
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, bus_error
    );
endinterface

// File: rtl/mips_bus_ram_bank.sv
// One word-addressed memory region: masked synchronous write, combinational read.
module mips_bus_ram_bank
    import mips_bus_pkg::*;
#(
    parameter int WORDS     = 1024,
    parameter     INIT_FILE = "",
    parameter int AW        = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Time-zero fill is a memory image, not a reset; contents survive reset.
    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
    end

    // NOTE: memory arrays get no reset branch so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= merge_bytes(mem[addr], wdata, be);
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mips_bus_memory.sv
// Avalon-MM slave memory with programmable waitrequest stretch and sticky error flag.
// Data region at 0, instruction region at INSTR_BASE; FSM latches each request.
module mips_bus_memory
    import mips_bus_pkg::*;
#(
    parameter int          DATA_WORDS  = 1024,
    parameter int          INSTR_WORDS = 1024,
    parameter logic [31:0] INSTR_BASE  = INSTR_BASE_DEFAULT,
    parameter int          WAIT_CYCLES = 1,
    parameter              INSTR_INIT  = "",
    parameter              DATA_INIT   = ""
) (
    input  logic     clk,
    input  logic     reset,
    mips_bus_if.slave bus
);

    localparam int          DATA_AW     = $clog2(DATA_WORDS);
    localparam int          INSTR_AW    = $clog2(INSTR_WORDS);
    localparam logic [31:0] DATA_LIMIT  = 32'(4 * DATA_WORDS);
    localparam logic [31:0] INSTR_LIMIT = INSTR_BASE + 32'(4 * INSTR_WORDS);

    state_t      state;
    logic [3:0]  count;
    logic [31:0] readdata_q;
    logic        bus_error_q;

    logic [31:0] lat_address;
    logic        lat_read;
    logic        lat_write;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;

    logic                data_hit;
    logic                instr_hit;
    logic [DATA_AW-1:0]  data_idx;
    logic [INSTR_AW-1:0] instr_idx;
    logic [31:0]         data_rd;
    logic [31:0]         instr_rd;
    logic [31:0]         rd_word;
    logic                hold_err;
    logic                commit;

    assign data_hit  = lat_address < DATA_LIMIT;
    assign instr_hit = (lat_address >= INSTR_BASE) && (lat_address < INSTR_LIMIT);
    assign data_idx  = DATA_AW'(lat_address >> 2);
    assign instr_idx = INSTR_AW'((lat_address - INSTR_BASE) >> 2);
    assign rd_word   = data_hit ? data_rd : (instr_hit ? instr_rd : 32'h0000_0000);

    assign hold_err = (bus.read != lat_read) || (bus.write != lat_write) ||
                      (bus.address != lat_address) || (bus.byteenable != lat_be) ||
                      (bus.writedata != lat_wdata);

    // Reset on the closing DONE edge must abandon the write.
    assign commit = (state == ST_DONE) && lat_write && !reset;

    mips_bus_ram_bank #(.WORDS(DATA_WORDS), .INIT_FILE(DATA_INIT)) u_data (
        .clk   (clk),
        .we    (commit && data_hit),
        .addr  (data_idx),
        .be    (lat_be),
        .wdata (lat_wdata),
        .rdata (data_rd)
    );

    mips_bus_ram_bank #(.WORDS(INSTR_WORDS), .INIT_FILE(INSTR_INIT)) u_instr (
        .clk   (clk),
        .we    (commit && instr_hit),
        .addr  (instr_idx),
        .be    (lat_be),
        .wdata (lat_wdata),
        .rdata (instr_rd)
    );

    // NOTE: all state updates use <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            readdata_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.read ^ bus.write) begin
                        lat_address <= bus.address;
                        lat_read    <= bus.read;
                        lat_write   <= bus.write;
                        lat_be      <= bus.byteenable;
                        lat_wdata   <= bus.writedata;
                        count       <= 4'(WAIT_CYCLES - 1);
                        state       <= ST_WAIT;
                    end else if (bus.read && bus.write) begin
                        bus_error_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (hold_err) bus_error_q <= 1'b1;
                    if (count == 4'd0) begin
                        readdata_q <= rd_word;
                        state      <= ST_DONE;
                        if (!(data_hit || instr_hit) || (lat_address[1:0] != 2'b00))
                            bus_error_q <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.waitrequest = (state != ST_DONE);
    assign bus.readdata    = readdata_q;
    assign bus.bus_error   = bus_error_q;

endmodule

// File: tb/tb_mips_bus_memory.sv
// Directed bench for mips_bus_memory: vector table plus multi-cycle corner sequences.
module tb_mips_bus_memory;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_bus_if bus1 ();
    mips_bus_if bus5 ();

    mips_bus_memory #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mips_bus_memory #(.WAIT_CYCLES(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] exp_rd,
                                input logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = !rd; v.addr = addr; v.be = be; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one request on bus1 from a negedge, sample mid-cycle until waitrequest drops.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdata, output int cycles);
        bus1.read = rd; bus1.write = wr; bus1.address = addr;
        bus1.byteenable = be; bus1.writedata = wd;
        cycles = 0;
        rdata = '0;
        for (int k = 0; k < 40; k++) begin
            #1;
            cycles++;
            if (!bus1.waitrequest) begin
                rdata = bus1.readdata;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus1.read = 1'b0; bus1.write = 1'b0;
    endtask

    logic [31:0] rdata;
    int          cycles;
    logic [13:0] pattern;
    logic [31:0] rd5;

    initial begin
        bus1.read = 0; bus1.write = 0; bus1.address = 0; bus1.byteenable = 0; bus1.writedata = 0;
        bus5.read = 0; bus5.write = 0; bus5.address = 0; bus5.byteenable = 0; bus5.writedata = 0;

        vecs.push_back(mk(0, 32'hBFC0_0000, 4'hF, 32'h2402_0005, 32'h0, 0));
        vecs.push_back(mk(1, 32'hBFC0_0000, 4'hF, 32'h0,         32'h2402_0005, 0));
        vecs.push_back(mk(0, 32'h0000_000C, 4'hF, 32'h1122_3344, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0000_000C, 4'h5, 32'hAABB_CCDD, 32'h0, 0));
        vecs.push_back(mk(1, 32'h0000_000C, 4'h0, 32'h0,         32'h11BB_33DD, 0));
        vecs.push_back(mk(0, 32'h0000_000C, 4'h0, 32'hFFFF_FFFF, 32'h0, 0));
        vecs.push_back(mk(1, 32'h0000_000C, 4'h0, 32'h0,         32'h11BB_33DD, 0));
        vecs.push_back(mk(0, 32'h0000_0010, 4'hC, 32'hCAFE_F00D, 32'h0, 0));
        vecs.push_back(mk(1, 32'h0000_0010, 4'h1, 32'h0,         32'hCAFE_0000, 0));
        vecs.push_back(mk(1, 32'h0000_0013, 4'hF, 32'h0,         32'hCAFE_0000, 1));
        vecs.push_back(mk(1, 32'h8000_0000, 4'hF, 32'h0,         32'h0000_0000, 1));
        vecs.push_back(mk(0, 32'h8000_0000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1));
        vecs.push_back(mk(0, 32'hBFC0_0FFC, 4'hF, 32'h1234_5678, 32'h0, 0));
        vecs.push_back(mk(1, 32'hBFC0_0FFC, 4'hF, 32'h0,         32'h1234_5678, 0));
        vecs.push_back(mk(1, 32'hBFC0_1000, 4'hF, 32'h0,         32'h0000_0000, 1));
        vecs.push_back(mk(1, 32'h0000_1000, 4'hF, 32'h0,         32'h0000_0000, 1));
        vecs.push_back(mk(0, 32'h0000_0000, 4'hF, 32'h55AA_55AA, 32'h0, 0));

        repeat (2) @(negedge clk);
        #1;
        check("rst_wait1", 32'(bus1.waitrequest), 32'd1);
        check("rst_rdata1", bus1.readdata, 32'h0);
        check("rst_err1", 32'(bus1.bus_error), 32'd0);
        check("rst_wait5", 32'(bus5.waitrequest), 32'd1);
        check("rst_rdata5", bus5.readdata, 32'h0);
        check("rst_err5", 32'(bus5.bus_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, rdata, cycles);
            check($sformatf("vec%0d_cycles", i), 32'(cycles), 32'd3);
            if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(bus1.bus_error), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) pulse_reset();
        end

        // read and write together: error, no access
        bus1.read = 1; bus1.write = 1; bus1.address = 32'hC; bus1.byteenable = 4'hF;
        bus1.writedata = 32'h0;
        #1 check("rw_wait", 32'(bus1.waitrequest), 32'd1);
        @(negedge clk);
        bus1.read = 0; bus1.write = 0;
        #1 check("rw_err", 32'(bus1.bus_error), 32'd1);
        check("rw_idle", 32'(bus1.waitrequest), 32'd1);
        @(negedge clk);
        pulse_reset();
        xfer(1, 0, 32'hC, 4'hF, 32'h0, rdata, cycles);
        check("rw_mem", rdata, 32'h11BB_33DD);

        // address changed while stalled: completes with latched address
        bus1.read = 1; bus1.address = 32'hC;
        @(negedge clk);
        bus1.address = 32'h10;
        @(negedge clk);
        #1 check("hold_done", 32'(bus1.waitrequest), 32'd0);
        check("hold_rdata", bus1.readdata, 32'h11BB_33DD);
        @(negedge clk);
        bus1.read = 0;
        #1 check("hold_err", 32'(bus1.bus_error), 32'd1);
        @(negedge clk);
        pulse_reset();

        // request dropped during WAIT: latched read still completes
        bus1.read = 1; bus1.address = 32'h0;
        @(negedge clk);
        bus1.read = 0;
        @(negedge clk);
        #1 check("drop_done", 32'(bus1.waitrequest), 32'd0);
        check("drop_rdata", bus1.readdata, 32'h55AA_55AA);
        @(negedge clk);
        #1 check("drop_err", 32'(bus1.bus_error), 32'd1);
        @(negedge clk);

        // reset during WAIT of a write to word 0
        bus1.write = 1; bus1.address = 32'h0; bus1.byteenable = 4'hF; bus1.writedata = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus1.write = 0;
        #1 check("rstw_wait", 32'(bus1.waitrequest), 32'd1);
        check("rstw_err", 32'(bus1.bus_error), 32'd0);
        @(negedge clk);

        // reset on the DONE edge beats the commit
        bus1.write = 1; bus1.address = 32'h0; bus1.byteenable = 4'hF; bus1.writedata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1 check("rstd_done", 32'(bus1.waitrequest), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus1.write = 0;
        xfer(1, 0, 32'h0, 4'hF, 32'h0, rdata, cycles);
        check("rst_mem", rdata, 32'h55AA_55AA);
        check("rst_mem_err", 32'(bus1.bus_error), 32'd0);

        // WAIT_CYCLES=5: two back-to-back reads with request held throughout
        rd5 = 32'hFFFF_FFFF;
        bus5.read = 1; bus5.address = 32'h4;
        for (int i = 0; i < 14; i++) begin
            #1;
            pattern[i] = bus5.waitrequest;
            if (i == 6) rd5 = bus5.readdata;
            @(negedge clk);
        end
        bus5.read = 0;
        check("w5_pattern", 32'(pattern), 32'(14'b01111110111111));
        check("w5_rdata", rd5, 32'h0);
        #1 check("w5_err", 32'(bus5.bus_error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
